// File: rtl/jtkcpu_busresp.sv
// jtkcpu_busresp: memory-side responder on the jtkcpu bus.
// It serves internal RAM and a slow external ROM through a one-entry cache.
// It stretches CPU cycles with dtack while data is not ready.
// It also hosts a control register for the interrupt lines and a periodic IRQ timer.
module jtkcpu_busresp #(
    parameter int RAMW = 12,
    parameter int ROMW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [23:0]     addr,
    input  logic [7:0]      cpu_dout,
    input  logic            we,
    output logic [7:0]      cpu_din,
    output logic            dtack,
    output logic            nmi_n,
    output logic            firq_n,
    output logic            irq_n,
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [7:0]      rom_data,
    output logic            finish,
    output logic            good
);

    localparam int RAMD = 1 << RAMW;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ROM_WAIT = 1'b1
    } state_t;

    // Address decode on the low 16 bits; the high byte only feeds ROM fetches and the 0x1001 readback
    logic [15:0]     a16;
    logic            ram_cs, ctrl_cs, id_cs, perl_cs, perh_cs, rom_reg;
    logic            rd, wr;
    logic [RAMW-1:0] ram_idx;

    assign a16     = addr[15:0];
    assign ram_cs  = (a16 >> RAMW) == 16'd0;
    assign ctrl_cs = a16 == 16'h1000;
    assign id_cs   = a16 == 16'h1001;
    assign perl_cs = a16 == 16'h1002;
    assign perh_cs = a16 == 16'h1003;
    assign rom_reg = a16[15:12] == 4'hF;
    assign rd      = ~we;
    assign wr      = we & cen;
    assign ram_idx = addr[RAMW-1:0];

    // Control and status state
    state_t          state_q, state_d;
    logic            dtack_q, dtack_d;
    logic [7:0]      cpu_din_q, cpu_din_d;
    logic            nmi_q, nmi_d, firq_q, firq_d, irq_q, irq_d;
    logic            nmi_n_q, firq_n_q, irq_n_q;
    logic            fin_q, fin_d, good_q, good_d;
    logic [15:0]     per_q, per_d, cnt_q, cnt_d;
    logic            cval_q, cval_d;
    logic            rdv_q, rdv_d;

    // Datapath storage (not reset)
    logic [7:0]      mem [RAMD];
    logic [7:0]      ram_q;
    logic [RAMW-1:0] prev_q;
    logic [23:0]     radr_q, radr_d;
    logic [23:0]     tag_q;
    logic [7:0]      cdat_q;

    logic            ram_new, rom_hit, rom_stall, fill;
    logic [15:0]     cnt_inc;

    // A RAM read stalls one cycle when its address was not the last one read (or RAM was just written)
    assign ram_new = rd & ram_cs & (~rdv_q | (ram_idx != prev_q));
    assign rom_hit = cval_q & (addr == tag_q);
    assign cnt_inc = cnt_q + 16'd1;

    // Control register and timer; expiry is applied after the CTRL write so it wins on a collision
    always_comb begin
        nmi_d  = nmi_q;
        firq_d = firq_q;
        irq_d  = irq_q;
        fin_d  = fin_q;
        good_d = good_q;
        per_d  = per_q;
        cnt_d  = cnt_q;
        rdv_d  = rdv_q;
        if (wr & ctrl_cs) begin
            fin_d                 = fin_q | cpu_dout[0];
            good_d                = cpu_dout[1];
            {nmi_d, firq_d, irq_d} = cpu_dout[7:5];
        end
        if (wr & perl_cs) per_d[7:0]  = cpu_dout;
        if (wr & perh_cs) per_d[15:8] = cpu_dout;
        if (wr & (perl_cs | perh_cs)) begin
            cnt_d = 16'd0;
        end else if (cen && per_q != 16'd0) begin
            if (cnt_inc == per_q) begin
                cnt_d = 16'd0;
                irq_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        if (wr & ram_cs)      rdv_d = 1'b0;
        else if (rd & ram_cs) rdv_d = 1'b1;
    end

    // ROM fetch FSM: next state, fetch address and stall/fill strobes
    always_comb begin
        state_d   = state_q;
        radr_d    = radr_q;
        rom_stall = 1'b0;
        fill      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd & rom_reg & ~rom_hit) begin
                    state_d   = ST_ROM_WAIT;
                    radr_d    = addr;
                    rom_stall = 1'b1;
                end
            end
            ST_ROM_WAIT: begin
                if (~(rd & rom_reg)) begin
                    // CPU moved away from ROM: abandon the fetch
                    state_d = ST_IDLE;
                end else if (addr != radr_q) begin
                    radr_d    = addr;
                    rom_stall = 1'b1;
                end else if (rom_ok) begin
                    fill    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rom_stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data mux and dtack; cpu_din holds its last value while a read is stalled
    always_comb begin
        dtack_d   = ~(ram_new | rom_stall);
        cpu_din_d = cpu_din_q;
        cval_d    = cval_q | fill;
        if (rd) begin
            if (ram_cs) begin
                if (!ram_new) cpu_din_d = ram_q;
            end else if (rom_reg) begin
                if (fill)                                 cpu_din_d = rom_data;
                else if (state_q == ST_IDLE && rom_hit)   cpu_din_d = cdat_q;
            end else if (ctrl_cs) begin
                cpu_din_d = {nmi_q, firq_q, irq_q, 3'b000, good_q, fin_q};
            end else if (id_cs) begin
                cpu_din_d = addr[23:16];
            end else if (perl_cs) begin
                cpu_din_d = per_q[7:0];
            end else if (perh_cs) begin
                cpu_din_d = per_q[15:8];
            end else begin
                cpu_din_d = 8'h00;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Control registers; interrupt outputs are registered inversions of the next latch values
    always_ff @(posedge clk) begin
        if (rst) begin
            dtack_q   <= 1'b1;
            cpu_din_q <= 8'h00;
            nmi_q     <= 1'b0;
            firq_q    <= 1'b0;
            irq_q     <= 1'b0;
            nmi_n_q   <= 1'b1;
            firq_n_q  <= 1'b1;
            irq_n_q   <= 1'b1;
            fin_q     <= 1'b0;
            good_q    <= 1'b0;
            per_q     <= 16'd0;
            cnt_q     <= 16'd0;
            cval_q    <= 1'b0;
            rdv_q     <= 1'b0;
        end else begin
            dtack_q   <= dtack_d;
            cpu_din_q <= cpu_din_d;
            nmi_q     <= nmi_d;
            firq_q    <= firq_d;
            irq_q     <= irq_d;
            nmi_n_q   <= ~nmi_d;
            firq_n_q  <= ~firq_d;
            irq_n_q   <= ~irq_d;
            fin_q     <= fin_d;
            good_q    <= good_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            cval_q    <= cval_d;
            rdv_q     <= rdv_d;
        end
    end

    // RAM array, read register, last-read address and ROM cache contents
    always_ff @(posedge clk) begin
        ram_q <= mem[ram_idx];
        if (wr & ram_cs) mem[ram_idx] <= cpu_dout;
        if (rd & ram_cs) prev_q <= ram_idx;
        radr_q <= radr_d;
        if (fill) begin
            tag_q  <= radr_q;
            cdat_q <= rom_data;
        end
    end

    assign cpu_din  = cpu_din_q;
    assign dtack    = dtack_q;
    assign nmi_n    = nmi_n_q;
    assign firq_n   = firq_n_q;
    assign irq_n    = irq_n_q;
    assign rom_addr = radr_q[ROMW-1:0];
    assign rom_cs   = (state_q == ST_ROM_WAIT);
    assign finish   = fin_q;
    assign good     = good_q;

endmodule
